// File: rtl/brush_writer.sv
// brush_writer: paints a square (or, with BRUSH_ROUND_EN defined, a disc) brush
// footprint into a frame buffer around each tracked pen position, and erases the
// whole buffer on request. One frame-buffer write slot per clock; outputs are registered.
// Optional feature macro: BRUSH_ROUND_EN (disc-shaped brush instead of square).
module brush_writer #(
   parameter int H_PIXELS     = 320,
   parameter int V_PIXELS     = 240,
   parameter int BRUSH_RADIUS = 2,
   parameter int ADDR_WIDTH   = 17
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  centroid_valid_in,
   input  logic [8:0]            x_in,
   input  logic [7:0]            y_in,
   input  logic                  pen_down_in,
   input  logic [1:0]            color_in,
   input  logic                  clear_in,
   output logic                  we_out,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic [7:0]            data_out,
   output logic                  busy_out
);

   localparam int WinSize    = 2 * BRUSH_RADIUS + 1;
   localparam int NumOffsets = WinSize * WinSize;
   localparam int NumPixels  = H_PIXELS * V_PIXELS;
   localparam logic signed [11:0] OffMin = 12'(-BRUSH_RADIUS);
   localparam logic signed [11:0] OffMax = 12'(BRUSH_RADIUS);
   localparam logic [15:0] PaintLast = 16'(NumOffsets);
   localparam logic [ADDR_WIDTH:0] ClrLast = (ADDR_WIDTH + 1)'(NumPixels);

   typedef enum logic [1:0] {StIdle, StPaint, StClear} state_e;

   state_e                  state_q;
   logic [8:0]              x_q;
   logic [7:0]              y_q;
   logic [1:0]              color_q;
   logic signed [11:0]      dx_q, dy_q;       // offset to be emitted next
   logic [15:0]             paint_cnt_q;      // offsets already emitted
   logic [ADDR_WIDTH:0]     clr_cnt_q;        // next clear address
   logic                    clear_pend_q;
   logic                    we_q, busy_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              data_q;

   logic [8:0]              base_x;
   logic [7:0]              base_y;
   logic [1:0]              base_color;
   logic signed [11:0]      cur_dx, cur_dy, nxt_dx, nxt_dy;
   int                      px, py;
   logic                    in_frame, shape_ok, pix_we;
   logic [ADDR_WIDTH-1:0]   pix_addr;

   // Pixel for the offset emitted on the coming edge; in IDLE it uses the live inputs so
   // the first brush write lands in the cycle right after capture.
   always_comb begin
      if (state_q == StIdle) begin
         base_x     = x_in;
         base_y     = y_in;
         base_color = color_in;
         cur_dx     = OffMin;
         cur_dy     = OffMin;
      end else begin
         base_x     = x_q;
         base_y     = y_q;
         base_color = color_q;
         cur_dx     = dx_q;
         cur_dy     = dy_q;
      end
      px       = int'(base_x) + int'(cur_dx);
      py       = int'(base_y) + int'(cur_dy);
      in_frame = (px >= 0) && (px < H_PIXELS) && (py >= 0) && (py < V_PIXELS);
`ifdef BRUSH_ROUND_EN
      shape_ok = (int'(cur_dx) * int'(cur_dx) + int'(cur_dy) * int'(cur_dy))
                 <= (BRUSH_RADIUS * BRUSH_RADIUS);
`else
      shape_ok = 1'b1;
`endif
      pix_we   = in_frame && shape_ok;
      pix_addr = ADDR_WIDTH'(py * H_PIXELS + px);
      if (cur_dx == OffMax) begin
         nxt_dx = OffMin;
         nxt_dy = cur_dy + 12'sd1;
      end else begin
         nxt_dx = cur_dx + 12'sd1;
         nxt_dy = cur_dy;
      end
   end

   // Control FSM with registered frame-buffer outputs; addr/data only move on a write.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= StIdle;
         x_q          <= '0;
         y_q          <= '0;
         color_q      <= '0;
         dx_q         <= '0;
         dy_q         <= '0;
         paint_cnt_q  <= '0;
         clr_cnt_q    <= '0;
         clear_pend_q <= 1'b0;
         we_q         <= 1'b0;
         busy_q       <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
      end else begin
         we_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (clear_in) begin
                  state_q   <= StClear;
                  busy_q    <= 1'b1;
                  we_q      <= 1'b1;
                  addr_q    <= '0;
                  data_q    <= 8'h00;
                  clr_cnt_q <= (ADDR_WIDTH + 1)'(1);
               end else if (centroid_valid_in && pen_down_in) begin
                  state_q     <= StPaint;
                  busy_q      <= 1'b1;
                  x_q         <= x_in;
                  y_q         <= y_in;
                  color_q     <= color_in;
                  we_q        <= pix_we;
                  if (pix_we) begin
                     addr_q <= pix_addr;
                     data_q <= {2'b11, 4'b0000, base_color};
                  end
                  dx_q        <= nxt_dx;
                  dy_q        <= nxt_dy;
                  paint_cnt_q <= 16'd1;
               end
            end
            StPaint: begin
               if (clear_in) clear_pend_q <= 1'b1;
               if (paint_cnt_q == PaintLast) begin
                  if (clear_pend_q || clear_in) begin
                     clear_pend_q <= 1'b0;
                     state_q      <= StClear;
                     we_q         <= 1'b1;
                     addr_q       <= '0;
                     data_q       <= 8'h00;
                     clr_cnt_q    <= (ADDR_WIDTH + 1)'(1);
                  end else begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  we_q <= pix_we;
                  if (pix_we) begin
                     addr_q <= pix_addr;
                     data_q <= {2'b11, 4'b0000, base_color};
                  end
                  dx_q        <= nxt_dx;
                  dy_q        <= nxt_dy;
                  paint_cnt_q <= paint_cnt_q + 16'd1;
               end
            end
            StClear: begin
               if (clr_cnt_q == ClrLast) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  we_q      <= 1'b1;
                  addr_q    <= clr_cnt_q[ADDR_WIDTH-1:0];
                  data_q    <= 8'h00;
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign we_out   = we_q;
   assign addr_out = addr_q;
   assign data_out = data_q;
   assign busy_out = busy_q;

endmodule

// File: tb/tb_brush_writer.sv
// Bench for brush_writer: a per-cycle expected stream (we, addr, data, busy) is built from
// the brush geometry with plain loops, then compared against the DUT cycle by cycle.
module tb_brush_writer;

   localparam int H  = 320;
   localparam int V  = 240;
   localparam int R  = 2;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cv = 1'b0, pd = 1'b0, clr = 1'b0;
   logic [8:0]    x = '0;
   logic [7:0]    y = '0;
   logic [1:0]    col = '0;
   logic          we, busy;
   logic [AW-1:0] addr;
   logic [7:0]    data;

   int total = 0;
   int bad   = 0;

   // Expected per-cycle stream; addr/data already carry the hold-last-value rule.
   logic       e_we[$];
   int         e_addr[$];
   logic [7:0] e_data[$];
   logic       e_busy[$];
   int         hold_addr = 0;
   logic [7:0] hold_data = 8'h00;

   brush_writer dut (
      .clk_in           (clk),
      .rst_n_in         (rst_n),
      .centroid_valid_in(cv),
      .x_in             (x),
      .y_in             (y),
      .pen_down_in      (pd),
      .color_in         (col),
      .clear_in         (clr),
      .we_out           (we),
      .addr_out         (addr),
      .data_out         (data),
      .busy_out         (busy)
   );

   always #5 clk = ~clk;

   function automatic void push_cycle(logic w, int a, logic [7:0] d, logic b);
      if (w) begin
         hold_addr = a;
         hold_data = d;
      end
      e_we.push_back(w);
      e_addr.push_back(hold_addr);
      e_data.push_back(hold_data);
      e_busy.push_back(b);
   endfunction

   function automatic void model_paint(int xb, int yb, logic [1:0] c);
      int px, py;
      bit ok;
      for (int dy = -R; dy <= R; dy++) begin
         for (int dx = -R; dx <= R; dx++) begin
            px = xb + dx;
            py = yb + dy;
            ok = (px >= 0) && (px < H) && (py >= 0) && (py < V);
`ifdef BRUSH_ROUND_EN
            ok = ok && (dx * dx + dy * dy <= R * R);
`endif
            push_cycle(ok, py * H + px, {2'b11, 4'b0000, c}, 1'b1);
         end
      end
   endfunction

   task automatic test_reset();
      #1;
      total++;
      if (we !== 1'b0 || busy !== 1'b0 || addr !== '0 || data !== 8'h00) begin
         bad++;
         $display("FAIL reset_hold: we=%b busy=%b addr=%0d data=%h, want all zero",
                  we, busy, addr, data);
      end
      cv = 1'b1; pd = 1'b1; x = 9'd100; y = 8'd50;
      repeat (3) @(negedge clk);
      cv = 1'b0;
      rst_n = 1'b1;
      hold_addr = 0; hold_data = 8'h00;
      repeat (3) @(negedge clk);
      total++;
      if (we !== 1'b0 || busy !== 1'b0 || addr !== '0 || data !== 8'h00) begin
         bad++;
         $display("FAIL reset_release: we=%b busy=%b addr=%0d data=%h, want all zero",
                  we, busy, addr, data);
      end
   endtask

   // Fixed geometry cases followed by random positions (including x beyond the frame).
   task automatic test_paint();
      int xs[4] = '{100, 0, 319, 1};
      int ys[4] = '{50, 0, 239, 238};
      logic [1:0] cs[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
`ifdef BRUSH_ROUND_EN
      int want_wr[2] = '{13, 6};
`else
      int want_wr[2] = '{25, 9};
`endif
      int xb, yb, nwr, nbusy, cyc;
      logic [1:0] c;
      logic w, b;
      int a;
      logic [7:0] d;
      for (int k = 0; k < 12; k++) begin
         if (k < 4) begin
            xb = xs[k]; yb = ys[k]; c = cs[k];
         end else begin
            xb = int'($urandom_range(0, 511));
            yb = int'($urandom_range(0, 255));
            c  = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
         x = 9'(xb); y = 8'(yb); col = c; pd = 1'b1; cv = 1'b1;
         model_paint(xb, yb, c);
         push_cycle(1'b0, 0, 8'h00, 1'b0);
         push_cycle(1'b0, 0, 8'h00, 1'b0);
         @(negedge clk);
         cv = 1'b0;
         nwr = 0; nbusy = 0; cyc = 0;
         while (e_we.size() > 0) begin
            w = e_we.pop_front(); a = e_addr.pop_front();
            d = e_data.pop_front(); b = e_busy.pop_front();
            nwr += int'(we === 1'b1);
            nbusy += int'(busy === 1'b1);
            total++;
            if (we !== w || busy !== b || addr !== AW'(a) || data !== d) begin
               bad++;
               $display("FAIL paint[%0d] cyc %0d (x=%0d y=%0d): we=%b busy=%b addr=%0d data=%h, want we=%b busy=%b addr=%0d data=%h",
                        k, cyc, xb, yb, we, busy, addr, data, w, b, a, d);
            end
            cyc++;
            @(negedge clk);
         end
         total++;
         if (nbusy != 25) begin
            bad++;
            $display("FAIL paint_busy_len[%0d]: got %0d cycles, want 25", k, nbusy);
         end
         if (k < 2) begin
            total++;
            if (nwr != want_wr[k]) begin
               bad++;
               $display("FAIL paint_wr_count[%0d]: got %0d, want %0d", k, nwr, want_wr[k]);
            end
         end
      end
   endtask

   // Second pulse mid-PAINT is dropped; a pen-up pulse in IDLE writes nothing.
   task automatic test_drop();
      logic w, b;
      int a, i;
      logic [7:0] d;
      @(negedge clk);
      x = 9'd150; y = 8'd100; col = 2'b10; pd = 1'b1; cv = 1'b1;
      model_paint(150, 100, 2'b10);
      push_cycle(1'b0, 0, 8'h00, 1'b0);
      push_cycle(1'b0, 0, 8'h00, 1'b0);
      @(negedge clk);
      cv = 1'b0;
      i = 0;
      while (e_we.size() > 0) begin
         w = e_we.pop_front(); a = e_addr.pop_front();
         d = e_data.pop_front(); b = e_busy.pop_front();
         total++;
         if (we !== w || busy !== b || addr !== AW'(a) || data !== d) begin
            bad++;
            $display("FAIL drop cyc %0d: we=%b busy=%b addr=%0d data=%h, want we=%b busy=%b addr=%0d data=%h",
                     i, we, busy, addr, data, w, b, a, d);
         end
         if (i == 4) begin
            x = 9'd10; y = 8'd10; col = 2'b01; pd = 1'b1; cv = 1'b1;
         end else begin
            cv = 1'b0;
         end
         i++;
         @(negedge clk);
      end
      x = 9'd20; y = 8'd20; col = 2'b11; pd = 1'b0; cv = 1'b1;
      repeat (30) push_cycle(1'b0, 0, 8'h00, 1'b0);
      @(negedge clk);
      cv = 1'b0;
      i = 0;
      while (e_we.size() > 0) begin
         w = e_we.pop_front(); a = e_addr.pop_front();
         d = e_data.pop_front(); b = e_busy.pop_front();
         total++;
         if (we !== w || busy !== b || addr !== AW'(a) || data !== d) begin
            bad++;
            $display("FAIL pen_up cyc %0d: we=%b busy=%b addr=%0d data=%h, want we=%b busy=%b addr=%0d data=%h",
                     i, we, busy, addr, data, w, b, a, d);
         end
         i++;
         @(negedge clk);
      end
   endtask

   // clear_in mid-PAINT chains into a full erase; a clear during CLEAR is ignored.
   task automatic test_clear_pending();
      logic w, b;
      int a, i, xb, yb;
      logic [7:0] d;
      xb = int'($urandom_range(10, 300));
      yb = int'($urandom_range(10, 220));
      @(negedge clk);
      x = 9'(xb); y = 8'(yb); col = 2'b01; pd = 1'b1; cv = 1'b1;
      model_paint(xb, yb, 2'b01);
      for (int p = 0; p < H * V; p++) push_cycle(1'b1, p, 8'h00, 1'b1);
      repeat (3) push_cycle(1'b0, 0, 8'h00, 1'b0);
      @(negedge clk);
      cv = 1'b0;
      i = 0;
      while (e_we.size() > 0) begin
         w = e_we.pop_front(); a = e_addr.pop_front();
         d = e_data.pop_front(); b = e_busy.pop_front();
         total++;
         if (we !== w || busy !== b || addr !== AW'(a) || data !== d) begin
            bad++;
            $display("FAIL clear_chain cyc %0d: we=%b busy=%b addr=%0d data=%h, want we=%b busy=%b addr=%0d data=%h",
                     i, we, busy, addr, data, w, b, a, d);
         end
         clr = (i == 9) || (i == 600);
         i++;
         @(negedge clk);
      end
      clr = 1'b0;
   endtask

   // Reset mid-CLEAR aborts at once; nothing resumes; a fresh pulse paints normally.
   task automatic test_reset_mid_clear();
      logic w, b;
      int a, i, xb, yb;
      logic [7:0] d;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      for (int p = 0; p <= 1000; p++) begin
         total++;
         if (we !== 1'b1 || busy !== 1'b1 || addr !== AW'(p) || data !== 8'h00) begin
            bad++;
            $display("FAIL clear_run addr %0d: we=%b busy=%b addr=%0d data=%h", p, we, busy,
                     addr, data);
         end
         if (p < 1000) @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (we !== 1'b0 || busy !== 1'b0 || addr !== '0 || data !== 8'h00) begin
         bad++;
         $display("FAIL async_reset: we=%b busy=%b addr=%0d data=%h, want all zero",
                  we, busy, addr, data);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold_addr = 0; hold_data = 8'h00;
      xb = int'($urandom_range(2, 317));
      yb = int'($urandom_range(2, 237));
      repeat (20) push_cycle(1'b0, 0, 8'h00, 1'b0);
      i = 0;
      while (e_we.size() > 0) begin
         w = e_we.pop_front(); a = e_addr.pop_front();
         d = e_data.pop_front(); b = e_busy.pop_front();
         if (i == 19) begin
            x = 9'(xb); y = 8'(yb); col = 2'b11; pd = 1'b1; cv = 1'b1;
            model_paint(xb, yb, 2'b11);
            push_cycle(1'b0, 0, 8'h00, 1'b0);
         end else begin
            cv = 1'b0;
         end
         total++;
         if (we !== w || busy !== b || addr !== AW'(a) || data !== d) begin
            bad++;
            $display("FAIL post_reset cyc %0d: we=%b busy=%b addr=%0d data=%h, want we=%b busy=%b addr=%0d data=%h",
                     i, we, busy, addr, data, w, b, a, d);
         end
         i++;
         @(negedge clk);
      end
      cv = 1'b0;
   endtask

   initial begin
      test_reset();
      test_paint();
      test_drop();
      test_clear_pending();
      test_reset_mid_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
